// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: on-chip instruction trace capture.
// Records {pc, instruction} on each cap_en strobe into a circular buffer.
// Capture runs free, or stops a programmable number of samples after a
// PC-match or external trigger. Once stopped (DONE), a host drains the
// trace oldest-first with rd_req and receives a one-cycle rd_valid per entry.
module cpu_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic              arm,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic              trig_in,
  input  logic [CNT_W-1:0]  post_count,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_instr,
  output logic [CNT_W-1:0]  count,
  output logic [1:0]        state,
  output logic              triggered
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Trace storage; never reset, only entries counted by count_q are meaningful.
  logic [2*DATA_W-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                triggered_q, triggered_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   trig_pc_q, trig_pc_d;
  logic [CNT_W-1:0]    post_cnt_q, post_cnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_pc_q, rd_pc_d;
  logic [DATA_W-1:0]   rd_instr_q, rd_instr_d;

  logic                wr_en;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_inc;
  logic                trig_hit;

  // Next-state, capture and readout control; arm overrides everything.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    triggered_d = triggered_q;
    mode_d      = mode_q;
    trig_pc_d   = trig_pc_q;
    post_cnt_d  = post_cnt_q;
    rd_valid_d  = 1'b0;
    rd_pc_d     = rd_pc_q;
    rd_instr_d  = rd_instr_q;
    wr_en       = 1'b0;

    // Oldest entry: wr_ptr minus the number held. Reading decrements count,
    // which moves this pointer forward without a separate register.
    rd_ptr    = wr_ptr_q - count_q[PTR_W-1:0];
    count_inc = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + 1'b1;
    // Mode 3 deliberately matches neither term, so it behaves as free-run.
    trig_hit  = ((mode_q == 2'd1) && (pc == trig_pc_q)) ||
                ((mode_q == 2'd2) && trig_in);

    if (arm) begin
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      remaining_d = '0;
      triggered_d = 1'b0;
      mode_d      = mode;
      trig_pc_d   = trig_pc;
      post_cnt_d  = post_count;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (cap_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_inc;
            if (trig_hit) begin
              triggered_d = 1'b1;
              if (post_cnt_q == '0) begin
                state_d = S_DONE;
              end else begin
                state_d     = S_POST;
                remaining_d = post_cnt_q;
              end
            end
          end
        end
        S_POST: begin
          if (cap_en) begin
            wr_en       = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            count_d     = count_inc;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == CNT_W'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (rd_req && (count_q != '0)) begin
            rd_valid_d = 1'b1;
            count_d    = count_q - 1'b1;
            {rd_pc_d, rd_instr_d} = mem[rd_ptr];
          end
        end
        default: begin
          // IDLE: hold everything until armed.
        end
      endcase
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      triggered_q <= 1'b0;
      mode_q      <= 2'd0;
      trig_pc_q   <= '0;
      post_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      triggered_q <= triggered_d;
      mode_q      <= mode_d;
      trig_pc_q   <= trig_pc_d;
      post_cnt_q  <= post_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_pc_q     <= rd_pc_d;
      rd_instr_q  <= rd_instr_d;
    end
  end

  // Trace memory write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {pc, instruction};
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_pc     = rd_pc_q;
  assign rd_instr  = rd_instr_q;
  assign count     = count_q;
  assign state     = state_q;
  assign triggered = triggered_q;

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable instruction-trace capture block attached beside the CPU core; samples the {pc, instruction} pair on each fetch strobe into a circular buffer.
- Generalises bench-only $monitor tracing into on-chip capture: parametrised width and depth, selectable trigger modes and a post-trigger window.
- After capture stops, a host reads the trace out oldest-first through a one-cycle request/valid handshake.

Parameters:
DATA_W, 32, width of pc and instruction fields
DEPTH, 16, number of trace entries; power of 2, minimum 2
CNT_W, $clog2(DEPTH)+1, width of count and post_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cap_en  input  1  sample strobe (CPU instruction_flag); one entry per cycle high
pc  input  DATA_W  current program counter
instruction  input  DATA_W  current instruction word
arm  input  1  start/restart capture; latches mode, trig_pc, post_count
mode  input  2  0 free-run, 1 PC-match trigger, 2 external trigger, 3 treated as 0
trig_pc  input  DATA_W  PC compare value for mode 1
trig_in  input  1  external trigger for mode 2
post_count  input  CNT_W  samples to capture after the trigger sample
rd_req  input  1  read one entry
rd_valid  output  1  one-cycle pulse; rd_pc/rd_instr valid
rd_pc  output  DATA_W  read-out pc
rd_instr  output  DATA_W  read-out instruction
count  output  CNT_W  entries held (saturates at DEPTH)
state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
triggered  output  1  sticky; set on trigger, cleared by arm or reset

Behaviour:
- Reset (async): state IDLE; wr_ptr, count, remaining 0; rd_valid, rd_pc, rd_instr, triggered 0. Memory contents need not be cleared.
- arm has priority in every state:
  - next cycle state is ARMED; wr_ptr, count and triggered are 0.
  - mode, trig_pc and post_count are latched. Later changes to these inputs are ignored until the next arm.
  - The sample present in the arm cycle is not stored.
- IDLE: no writes; rd_req ignored.
- ARMED, each cycle with cap_en=1:
  - writes {pc, instruction} at wr_ptr; wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH. Once full, the oldest entry is overwritten.
- Trigger, evaluated only in ARMED with cap_en=1:
  - mode 1: pc == latched trig_pc.
  - mode 2: trig_in=1.
  - mode 0/3: never triggers; capture runs until re-armed.
- On trigger:
  - the trigger sample is stored and triggered is set.
  - latched post_count = 0: next state DONE.
  - otherwise: next state POST, with remaining = post_count.
- POST:
  - each cap_en=1 sample is stored (same wrap and saturation rules) and remaining decrements.
  - when the stored sample brings remaining to 0, next state is DONE.
  - trig_in and PC matches are ignored.
- DONE:
  - no writes; cap_en ignored.
  - read pointer = (wr_ptr − count) mod DEPTH, i.e. the oldest entry.
- Read, in DONE only:
  - rd_req=1 with count>0: the next cycle gives rd_valid=1 with the oldest entry on rd_pc/rd_instr. The read pointer advances and count decrements in the same edge.
  - rd_req held high drains one entry per cycle.
  - rd_req with count=0, or outside DONE: ignored, no rd_valid.
  - rd_pc/rd_instr hold their last value while rd_valid=0.
- Simultaneous arm and rd_req: arm wins; no rd_valid is produced.
- Reset during POST or readout: immediate return to reset values.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → state=0, count=0, rd_valid=0, triggered=0 at once, with no clock edge needed.
- Mode 1 without wrap: arm with trig_pc=0x20, post_count=3; cap_en every cycle with pc 0x00,0x04,… → DONE after pc 0x2C, count=12. Twelve reads return pc 0x00..0x2C in order, then rd_req produces nothing.
- Wrap: mode 1, trig_pc=0x80, post_count=0; pcs 0x00..0x80 (33 samples) → count=16; reads return 0x44..0x80.
- Gaps: mode 2, cap_en toggling 1,0,1,0; trig_in pulsed while cap_en=0 → no trigger. Pulsed while cap_en=1 → triggered=1. Only cap_en=1 samples are stored.
- Re-arm in POST: mode 1 triggered with post_count=5; arm after 2 post samples → state ARMED, count=0, triggered=0, and the old data is not readable.
- Read edge cases: rd_req in ARMED → no rd_valid. rd_req together with arm in DONE → state ARMED, no rd_valid. Mode 0 capture of 40 samples stays in ARMED, count=16.
